// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared encodings and helpers for the branch predictor
// Two-bit counter encodings and the mispredict rule used on the update path.
package branch_predictor_pkg;

  localparam logic [1:0] CTR_SNT   = 2'b00;
  localparam logic [1:0] CTR_WNT   = 2'b01;
  localparam logic [1:0] CTR_WT    = 2'b10;
  localparam logic [1:0] CTR_ST    = 2'b11;
  localparam logic [1:0] CTR_RESET = CTR_WNT;

  // A taken branch with the right direction but a stale target still redirects.
  function automatic logic is_mispredict(
    input logic        pred_taken,
    input logic        taken,
    input logic [31:0] pred_target,
    input logic [31:0] target
  );
    return (pred_taken != taken) || (taken && (pred_target != target));
  endfunction

endpackage

// File: rtl/sat_counter2.sv
// rtl/sat_counter2.sv - 2-bit saturating counter next-state logic
// Taken steps toward strong-taken, not-taken toward strong-not-taken.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       taken,
  output logic [1:0] next
);

  always_comb begin
    next = cur;
    if (taken) begin
      if (cur != CTR_ST) next = cur + 2'd1;
    end else begin
      if (cur != CTR_SNT) next = cur - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped direction/target predictor with redirect and stats
// Combinational lookup at fetch; training, redirect and counters from resolved branches.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] fetchPc,
  output logic        predHit,
  output logic        predTaken,
  output logic [31:0] predTarget,
  input  logic        updValid,
  input  logic [31:0] updPc,
  input  logic        updTaken,
  input  logic [31:0] updTarget,
  input  logic        updPredTaken,
  input  logic [31:0] updPredTarget,
  input  logic        flush,
  output logic        redirectValid,
  output logic [31:0] redirectPc,
  output logic [31:0] branchCount,
  output logic [31:0] mispredictCount
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [31:0]        r_target [ENTRIES];
  logic [1:0]         r_ctr    [ENTRIES];

  logic [IDX_W-1:0] w_fidx;
  logic [TAG_W-1:0] w_ftag;
  logic [IDX_W-1:0] w_uidx;
  logic [TAG_W-1:0] w_utag;
  logic             w_uhit;
  logic [1:0]       w_ctr_next;
  logic             w_misp;
  logic [31:0]      w_redirect_pc;
  logic             w_unused;

  assign w_fidx = fetchPc[IDX_W+1:2];
  assign w_ftag = fetchPc[IDX_W+TAG_W+1:IDX_W+2];
  assign w_uidx = updPc[IDX_W+1:2];
  assign w_utag = updPc[IDX_W+TAG_W+1:IDX_W+2];

  // Fetch PC bits outside index and tag play no part in the lookup.
  assign w_unused = ^{fetchPc[31:IDX_W+TAG_W+2], fetchPc[1:0]};

  assign predHit    = r_valid[w_fidx] && (r_tag[w_fidx] == w_ftag);
  assign predTaken  = predHit && r_ctr[w_fidx][1];
  assign predTarget = predHit ? r_target[w_fidx] : 32'd0;

  assign w_uhit        = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
  assign w_misp        = is_mispredict(updPredTaken, updTaken, updPredTarget, updTarget);
  assign w_redirect_pc = updTaken ? updTarget : (updPc + 32'd4);

  sat_counter2 u_sat_counter2 (
    .cur   (r_ctr[w_uidx]),
    .taken (updTaken),
    .next  (w_ctr_next)
  );

  // Flush only clears valid bits; it also blocks any training write that cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= CTR_RESET;
      end
    end else if (flush) begin
      r_valid <= '0;
    end else if (updValid) begin
      if (w_uhit) begin
        r_ctr[w_uidx] <= w_ctr_next;
        if (updTaken) r_target[w_uidx] <= updTarget;
      end else if (updTaken) begin
        r_valid[w_uidx]  <= 1'b1;
        r_tag[w_uidx]    <= w_utag;
        r_target[w_uidx] <= updTarget;
        r_ctr[w_uidx]    <= CTR_WT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      redirectValid   <= 1'b0;
      redirectPc      <= 32'd0;
      branchCount     <= 32'd0;
      mispredictCount <= 32'd0;
    end else begin
      redirectValid <= updValid && w_misp;
      if (updValid) begin
        branchCount <= branchCount + 32'd1;
        if (w_misp) begin
          mispredictCount <= mispredictCount + 32'd1;
          redirectPc      <= w_redirect_pc;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - self-checking bench for branch_predictor
// Redirect expectations are queued when an update is driven and compared after the edge.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] fetchPc;
  logic        predHit;
  logic        predTaken;
  logic [31:0] predTarget;
  logic        updValid;
  logic [31:0] updPc;
  logic        updTaken;
  logic [31:0] updTarget;
  logic        updPredTaken;
  logic [31:0] updPredTarget;
  logic        flush;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic [31:0] branchCount;
  logic [31:0] mispredictCount;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_branch;
  logic [31:0] m_misp;
  logic [31:0] m_rpc;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(64), .TAG_W(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fetchPc         (fetchPc),
    .predHit         (predHit),
    .predTaken       (predTaken),
    .predTarget      (predTarget),
    .updValid        (updValid),
    .updPc           (updPc),
    .updTaken        (updTaken),
    .updTarget       (updTarget),
    .updPredTaken    (updPredTaken),
    .updPredTarget   (updPredTarget),
    .flush           (flush),
    .redirectValid   (redirectValid),
    .redirectPc      (redirectPc),
    .branchCount     (branchCount),
    .mispredictCount (mispredictCount)
  );

  task automatic upd_set(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt, input logic fl, input logic rs);
    logic misp;
    @(negedge clk);
    rst_n         = rs;
    updValid      = 1'b1;
    updPc         = pc;
    updTaken      = tk;
    updTarget     = tgt;
    updPredTaken  = ptk;
    updPredTarget = ptgt;
    flush         = fl;
    misp = (ptk != tk) || (tk && (ptgt != tgt));
    if (!rs) begin
      m_branch = 0;
      m_misp   = 0;
      m_rpc    = 0;
      sb.push_back('{v: 1'b0, pc: 32'h0});
    end else begin
      m_branch = m_branch + 1;
      if (misp) begin
        m_misp = m_misp + 1;
        m_rpc  = tk ? tgt : pc + 32'd4;
      end
      sb.push_back('{v: misp, pc: m_rpc});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    updValid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; updValid = 1'b0; flush = 1'b0; fetchPc = 32'h100;
    updPc = 0; updTaken = 0; updTarget = 0; updPredTaken = 0; updPredTarget = 0;
    m_branch = 0; m_misp = 0; m_rpc = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (predHit !== 1'b0 || predTaken !== 1'b0 || predTarget !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_pred: got hit=%b taken=%b tgt=%h, expected 0 0 0", predHit, predTaken, predTarget);
    end
    n_checks++;
    if (branchCount !== 32'h0 || mispredictCount !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_stats: got br=%0d mp=%0d, expected 0 0", branchCount, mispredictCount);
    end
    n_checks++;
    if (redirectValid !== 1'b0 || redirectPc !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_redirect: got v=%b pc=%h, expected 0 0", redirectValid, redirectPc);
    end
  endtask

  task automatic test_allocate();
    upd_set(32'h100, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    e = sb.pop_front();
    n_checks++;
    if (redirectValid !== e.v || redirectPc !== e.pc) begin
      n_errors++;
      $display("FAIL alloc_redirect: got v=%b pc=%h, expected v=%b pc=%h", redirectValid, redirectPc, e.v, e.pc);
    end
    fetchPc = 32'h100;
    #1;
    n_checks++;
    if (predHit !== 1'b1 || predTaken !== 1'b1 || predTarget !== 32'h80) begin
      n_errors++;
      $display("FAIL alloc_pred: got hit=%b taken=%b tgt=%h, expected 1 1 00000080", predHit, predTaken, predTarget);
    end
    n_checks++;
    if (branchCount !== m_branch || mispredictCount !== m_misp) begin
      n_errors++;
      $display("FAIL alloc_stats: got br=%0d mp=%0d, expected %0d %0d", branchCount, mispredictCount, m_branch, m_misp);
    end
  endtask

  // Counter 10 -> 01 -> 00 -> 00 -> 00, then taken twice: 01 (still NT), 10 (T).
  task automatic test_counter_walk();
    logic [5:0] tk_v   = 6'b110000;
    logic [5:0] ptk_v  = 6'b000001;
    logic [5:0] expt_v = 6'b100000;
    for (int i = 0; i < 6; i++) begin
      upd_set(32'h100, tk_v[i], 32'h80, ptk_v[i], 32'h80, 1'b0, 1'b1);
      tick();
      e = sb.pop_front();
      n_checks++;
      if (redirectValid !== e.v || redirectPc !== e.pc) begin
        n_errors++;
        $display("FAIL walk_redirect[%0d]: got v=%b pc=%h, expected v=%b pc=%h", i, redirectValid, redirectPc, e.v, e.pc);
      end
      fetchPc = 32'h100;
      #1;
      n_checks++;
      if (predHit !== 1'b1 || predTaken !== expt_v[i]) begin
        n_errors++;
        $display("FAIL walk_pred[%0d]: got hit=%b taken=%b, expected 1 %b", i, predHit, predTaken, expt_v[i]);
      end
    end
    n_checks++;
    if (branchCount !== m_branch || mispredictCount !== m_misp) begin
      n_errors++;
      $display("FAIL walk_stats: got br=%0d mp=%0d, expected %0d %0d", branchCount, mispredictCount, m_branch, m_misp);
    end
  endtask

  task automatic test_alias();
    fetchPc = 32'h200;
    #1;
    n_checks++;
    if (predHit !== 1'b0) begin
      n_errors++;
      $display("FAIL alias_miss: got hit=%b, expected 0", predHit);
    end
    upd_set(32'h200, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    e = sb.pop_front();
    n_checks++;
    if (redirectValid !== e.v || redirectPc !== e.pc) begin
      n_errors++;
      $display("FAIL alias_redirect: got v=%b pc=%h, expected v=%b pc=%h", redirectValid, redirectPc, e.v, e.pc);
    end
    fetchPc = 32'h100;
    #1;
    n_checks++;
    if (predHit !== 1'b0) begin
      n_errors++;
      $display("FAIL alias_evicted: got hit=%b, expected 0", predHit);
    end
    fetchPc = 32'h200;
    #1;
    n_checks++;
    if (predHit !== 1'b1 || predTaken !== 1'b1 || predTarget !== 32'h300) begin
      n_errors++;
      $display("FAIL alias_new: got hit=%b taken=%b tgt=%h, expected 1 1 00000300", predHit, predTaken, predTarget);
    end
  endtask

  task automatic test_same_cycle();
    upd_set(32'h200, 1'b1, 32'h400, 1'b1, 32'h300, 1'b0, 1'b1);
    fetchPc = 32'h200;
    #1;
    n_checks++;
    if (predHit !== 1'b1 || predTarget !== 32'h300) begin
      n_errors++;
      $display("FAIL same_cycle_old: got hit=%b tgt=%h, expected 1 00000300", predHit, predTarget);
    end
    tick();
    e = sb.pop_front();
    n_checks++;
    if (redirectValid !== e.v || redirectPc !== e.pc) begin
      n_errors++;
      $display("FAIL same_cycle_redirect: got v=%b pc=%h, expected v=%b pc=%h", redirectValid, redirectPc, e.v, e.pc);
    end
    n_checks++;
    if (predTaken !== 1'b1 || predTarget !== 32'h400) begin
      n_errors++;
      $display("FAIL same_cycle_new: got taken=%b tgt=%h, expected 1 00000400", predTaken, predTarget);
    end
  endtask

  task automatic test_flush();
    upd_set(32'h104, 1'b1, 32'h500, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    e = sb.pop_front();
    n_checks++;
    if (redirectValid !== e.v || redirectPc !== e.pc) begin
      n_errors++;
      $display("FAIL flush_redirect: got v=%b pc=%h, expected v=%b pc=%h", redirectValid, redirectPc, e.v, e.pc);
    end
    fetchPc = 32'h200;
    #1;
    n_checks++;
    if (predHit !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_old_entry: got hit=%b, expected 0", predHit);
    end
    fetchPc = 32'h104;
    #1;
    n_checks++;
    if (predHit !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_upd_entry: got hit=%b, expected 0", predHit);
    end
    n_checks++;
    if (branchCount !== m_branch || mispredictCount !== m_misp) begin
      n_errors++;
      $display("FAIL flush_stats: got br=%0d mp=%0d, expected %0d %0d", branchCount, mispredictCount, m_branch, m_misp);
    end
  endtask

  task automatic test_wrap();
    upd_set(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1);
    tick();
    e = sb.pop_front();
    n_checks++;
    if (redirectValid !== e.v || redirectPc !== e.pc) begin
      n_errors++;
      $display("FAIL wrap_redirect: got v=%b pc=%h, expected v=%b pc=%h", redirectValid, redirectPc, e.v, e.pc);
    end
    fetchPc = 32'hFFFF_FFFC;
    #1;
    n_checks++;
    if (predHit !== 1'b0) begin
      n_errors++;
      $display("FAIL wrap_no_alloc: got hit=%b, expected 0", predHit);
    end
  endtask

  task automatic test_reset_pending();
    upd_set(32'h100, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    e = sb.pop_front();
    n_checks++;
    if (redirectValid !== e.v || redirectPc !== e.pc) begin
      n_errors++;
      $display("FAIL pre_reset_redirect: got v=%b pc=%h, expected v=%b pc=%h", redirectValid, redirectPc, e.v, e.pc);
    end
    upd_set(32'h108, 1'b1, 32'h600, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    e = sb.pop_front();
    n_checks++;
    if (redirectValid !== e.v || redirectPc !== e.pc) begin
      n_errors++;
      $display("FAIL reset_redirect_drop: got v=%b pc=%h, expected v=%b pc=%h", redirectValid, redirectPc, e.v, e.pc);
    end
    n_checks++;
    if (branchCount !== 32'h0 || mispredictCount !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_stats_clear: got br=%0d mp=%0d, expected 0 0", branchCount, mispredictCount);
    end
    @(negedge clk);
    rst_n = 1'b1;
    fetchPc = 32'h100;
    #1;
    n_checks++;
    if (predHit !== 1'b0 || predTarget !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_table_clear: got hit=%b tgt=%h, expected 0 0", predHit, predTarget);
    end
    fetchPc = 32'h108;
    #1;
    n_checks++;
    if (predHit !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_upd_dropped: got hit=%b, expected 0", predHit);
    end
    upd_set(32'h200, 1'b1, 32'h700, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    e = sb.pop_front();
    n_checks++;
    if (redirectValid !== e.v || redirectPc !== e.pc) begin
      n_errors++;
      $display("FAIL post_reset_redirect: got v=%b pc=%h, expected v=%b pc=%h", redirectValid, redirectPc, e.v, e.pc);
    end
    n_checks++;
    if (branchCount !== m_branch || mispredictCount !== m_misp) begin
      n_errors++;
      $display("FAIL post_reset_stats: got br=%0d mp=%0d, expected %0d %0d", branchCount, mispredictCount, m_branch, m_misp);
    end
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_counter_walk();
    test_alias();
    test_same_cycle();
    test_flush();
    test_wrap();
    test_reset_pending();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-stage direction and target predictor for the RV32I core. It is the front end of the branch path: it predicts taken/not-taken and the target at fetch. The execute-stage branch comparator later resolves the branch, and that resolution is fed back here to train the tables and to raise a registered redirect on mispredict. Direct-mapped table of 2-bit saturating counters plus tagged targets, with branch and mispredict statistics counters.

## Interface
- ENTRIES, 64, number of table entries; power of two, ≥4; IDX_W = log2(ENTRIES)
- TAG_W, 8, stored tag bits taken from PC above the index
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- fetchPc  input  32  PC being fetched
- predHit  output  1  valid entry with matching tag at fetchPc (combinational)
- predTaken  output  1  predHit && counter[1] (combinational)
- predTarget  output  32  stored target; 0 when !predHit (combinational)
- updValid  input  1  one resolved conditional branch this cycle
- updPc  input  32  PC of the resolved branch
- updTaken  input  1  comparator outcome
- updTarget  input  32  computed branch target
- updPredTaken  input  1  prediction that travelled with the branch
- updPredTarget  input  32  predicted target that travelled with the branch
- flush  input  1  invalidate all entries
- redirectValid  output  1  registered one-cycle mispredict pulse
- redirectPc  output  32  correct next PC, registered
- branchCount  output  32  resolved branches since reset
- mispredictCount  output  32  mispredicts since reset

## Operation
- Index = pc[IDX_W+1:2]. Tag = pc[IDX_W+TAG_W+1:IDX_W+2]. pc[1:0] is ignored.
- Per entry: valid bit, tag, 32-bit target, 2-bit counter.
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  - Taken increments the counter, saturating at 11.
  - Not-taken decrements the counter, saturating at 00.
- Lookup is an asynchronous read of the registered table.
- Update when updValid, tag hit:
  - Step the counter.
  - If updTaken, overwrite the target with updTarget.
- Update when updValid, miss:
  - Taken: allocate the entry. Set valid=1, write tag, target=updTarget, counter=10.
  - Not-taken: no table write.
- Mispredict when (updPredTaken != updTaken) || (updTaken && updPredTarget != updTarget).
- redirectPc = updTaken ? updTarget : updPc+4, computed mod 2^32, so 0xFFFFFFFC+4 wraps to 0.
- Counters:
  - branchCount increments on every updValid.
  - mispredictCount increments on every mispredict.
  - Both wrap from 0xFFFFFFFF to 0.

## Timing
- Prediction latency is 0 cycles, combinational from fetchPc.
- Table writes occur at the clk edge of the cycle with updValid. A lookup of the same index in that cycle returns the pre-update contents.
- redirectValid/redirectPc assert on the edge after the updValid cycle, for exactly one cycle. Back-to-back mispredicts give back-to-back pulses.
- redirectPc holds its last value when redirectValid=0.
- flush clears every valid bit at the next edge; counters, tags and targets are untouched. flush with updValid in the same cycle: flush wins for the table, but redirect and statistics still update from that branch.
- Reset (rst_n=0 at an edge):
  - All valid bits clear and all table counters go to 01.
  - redirectValid=0, redirectPc=0, branchCount=0, mispredictCount=0.
  - Reset during a pending redirect suppresses the pulse.
  - Reset has priority over flush and updValid.
- Any updValid sampled while rst_n=0 is dropped.

## Structure
- defines.vh gains the counter encodings (SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11) and the reset counter value.
- Sub-module sat_counter2: 2-bit saturating next-state logic (inputs cur, taken; output next), instantiated once on the update path.
- Table is held in flops (reset and flush need bulk clears), not inferred RAM.

## Test plan
- Reset, then fetchPc=0x100 → predHit=0, predTaken=0, predTarget=0; both statistics counters=0.
- Update pc=0x100, taken=1, target=0x80, predTaken=0 → next cycle redirectValid=1 and redirectPc=0x80; fetchPc=0x100 gives predHit=1, predTaken=1, predTarget=0x80; mispredictCount=1.
- Starting from the state above, four not-taken updates at 0x100 → counter goes 10→01→00→00→00. predTaken=0 after the first. Only mismatching predictions raise redirect, with redirectPc=0x104.
- Alias: pc=0x100 allocated, then fetch pc = 0x100 + 4·ENTRIES (same index, different tag) → predHit=0. Taken update there replaces the entry, and 0x100 then misses.
- Same-cycle update and lookup of 0x200 → old prediction returned. Assert flush together with a taken update → all predHit=0 next cycle, branchCount still increments.
- Drop rst_n in the cycle after a mispredicting update → no redirect pulse; all counters and tables return to reset values.
